// File: rtl/matrix_sub_sequencer_pkg.sv
// Shared constants, state encoding and element addressing for the matrix subtraction sequencer.
package matrix_sub_sequencer_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int MAT_W  = ELEM_W * N_ELEM;
    localparam int IDX_W  = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Element i lives at bits [ELEM_W*i +: ELEM_W] of a packed matrix.
    function automatic int elem_lsb(input int idx);
        return idx * ELEM_W;
    endfunction

endpackage

// File: rtl/matrix_sub_sequencer_subtractor.sv
// Combinational 5x5 signed 8-bit matrix subtractor: R = A - B with wraparound and OR-ed overflow.
module MatrixSubtractor
    import matrix_sub_sequencer_pkg::*;
(
    input  logic [MAT_W-1:0] matrix_a,
    input  logic [MAT_W-1:0] matrix_b,
    output logic [MAT_W-1:0] result_out,
    output logic             overflow
);

    logic [ELEM_W-1:0] a_e;
    logic [ELEM_W-1:0] b_e;
    logic [ELEM_W-1:0] d_e;

    always_comb begin
        result_out = '0;
        overflow   = 1'b0;
        a_e        = '0;
        b_e        = '0;
        d_e        = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            a_e = matrix_a[elem_lsb(i) +: ELEM_W];
            b_e = matrix_b[elem_lsb(i) +: ELEM_W];
            d_e = a_e - b_e;
            result_out[elem_lsb(i) +: ELEM_W] = d_e;
            // Signed subtract overflows only when operand signs differ and the result flips away from A.
            overflow = overflow | ((a_e[ELEM_W-1] != b_e[ELEM_W-1]) && (d_e[ELEM_W-1] != a_e[ELEM_W-1]));
        end
    end

endmodule

// File: rtl/matrix_sub_sequencer.sv
// Byte-serial load / execute / stream-out sequencer around the matrix subtractor.
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD_A  | accepting 25 elements of A
//   LOAD_B  | accepting 25 elements of B
//   EXEC    | one cycle: capture difference and overflow
//   OUT     | streaming 25 result elements
module matrix_sub_sequencer
    import matrix_sub_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ELEM_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [MAT_W-1:0] a_reg;
    logic [MAT_W-1:0] b_reg;
    logic [MAT_W-1:0] r_reg;
    logic [MAT_W-1:0] sub_result;
    logic             sub_overflow;

    MatrixSubtractor u_subtractor (
        .matrix_a   (a_reg),
        .matrix_b   (b_reg),
        .result_out (sub_result),
        .overflow   (sub_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            r_reg    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            // clear outranks start and every handshake; data registers are deliberately kept.
            if (clear) begin
                state    <= ST_IDLE;
                idx      <= '0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state    <= ST_LOAD_A;
                            idx      <= '0;
                            overflow <= 1'b0;
                        end
                    end
                    ST_LOAD_A: begin
                        if (in_valid) begin
                            a_reg[elem_lsb(int'(idx)) +: ELEM_W] <= in_data;
                            if (idx == LAST_IDX) begin
                                state <= ST_LOAD_B;
                                idx   <= '0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_LOAD_B: begin
                        if (in_valid) begin
                            b_reg[elem_lsb(int'(idx)) +: ELEM_W] <= in_data;
                            if (idx == LAST_IDX) begin
                                state <= ST_EXEC;
                                idx   <= '0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_EXEC: begin
                        r_reg    <= sub_result;
                        overflow <= sub_overflow;
                        state    <= ST_OUT;
                        idx      <= '0;
                    end
                    ST_OUT: begin
                        if (out_ready) begin
                            if (idx == LAST_IDX) begin
                                state <= ST_IDLE;
                                idx   <= '0;
                                done  <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign out_valid = (state == ST_OUT);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign busy      = (state != ST_IDLE);
    assign out_data  = out_valid ? r_reg[elem_lsb(int'(idx)) +: ELEM_W] : '0;

endmodule

// File: tb/tb_matrix_sub_sequencer.sv
// Self-checking bench for matrix_sub_sequencer: vector table, hand-written corner sequences, random runs vs. model.
module tb_matrix_sub_sequencer;
    import matrix_sub_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       overflow;

    matrix_sub_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ma [N_ELEM];
    logic [7:0] mb [N_ELEM];
    logic [7:0] er [N_ELEM];
    logic       eovf;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer difference of signed values, wrapped to 8 bits; overflow when outside [-128,127].
    task automatic model();
        eovf = 1'b0;
        for (int i = 0; i < N_ELEM; i++) begin
            int sa;
            int sb;
            int d;
            sa = $signed(ma[i]);
            sb = $signed(mb[i]);
            d  = sa - sb;
            er[i] = d[7:0];
            if (d > 127 || d < -128) eovf = 1'b1;
        end
    endtask

    function automatic logic [7:0] rand_elem();
        logic [7:0] edges [4];
        edges[0] = 8'h7F;
        edges[1] = 8'h80;
        edges[2] = 8'h00;
        edges[3] = 8'hFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N_ELEM; i++) begin
            ma[i] = rand_elem();
            mb[i] = rand_elem();
        end
        model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic begin_op();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        start    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        out_ready = 1'b0;
    endtask

    task automatic load_mat(input bit is_b, input int n_beats, input bit gaps, input bit poke);
        int k = 0;
        int guard = 0;
        while (k < n_beats) begin
            @(negedge clk);
            start = poke && (k == 10);
            check("load_in_ready", in_ready, 1);
            check("load_out_valid", out_valid, 0);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? (is_b ? mb[k] : ma[k]) : 8'($urandom);
            if (in_valid && in_ready) k++;
            guard++;
            if (guard > 2000) begin
                check("load_timeout", k, n_beats);
                break;
            end
        end
    endtask

    task automatic exec_phase();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        check("exec_in_ready", in_ready, 0);
        check("exec_out_valid", out_valid, 0);
        check("exec_busy", busy, 1);
    endtask

    task automatic unload(input bit bp, input bit poke, input int clear_after);
        int  j = 0;
        int  cyc = 0;
        bit  cleared = 0;
        while (j < N_ELEM) begin
            @(negedge clk);
            check("out_valid", out_valid, 1);
            check($sformatf("out_data[%0d]", j), out_data, er[j]);
            check("out_last", out_last, (j == N_ELEM - 1));
            check("out_overflow", overflow, eovf);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            start    = poke && (cyc == 3);
            if (clear_after >= 0 && j == clear_after) begin
                clear     = 1'b1;
                out_ready = 1'b1;
                cleared   = 1;
                break;
            end
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (out_ready) j++;
            cyc++;
            if (cyc > 2000) begin
                check("unload_timeout", j, N_ELEM);
                break;
            end
        end
        @(negedge clk);
        start     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'($urandom);
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_done", done, cleared ? 0 : 1);
        check("post_overflow", overflow, cleared ? 1'b0 : eovf);
        @(negedge clk);
        out_ready = 1'b0;
        check("done_one_cycle", done, 0);
        check("overflow_hold", overflow, cleared ? 1'b0 : eovf);
    endtask

    task automatic run_op(input bit gaps, input bit bp, input bit poke, input int clear_after);
        begin_op();
        load_mat(1'b0, N_ELEM, gaps, 1'b0);
        load_mat(1'b1, N_ELEM, gaps, poke);
        exec_phase();
        unload(bp, poke, clear_after);
    endtask

    initial begin
        vecs[0] = '{"basic_10_3",  8'h0A, 8'h03, 8'h07, 1'b0};
        vecs[1] = '{"equal_5_5",   8'h05, 8'h05, 8'h00, 1'b0};
        vecs[2] = '{"7f_minus_ff", 8'h7F, 8'hFF, 8'h80, 1'b1};
        vecs[3] = '{"80_minus_01", 8'h80, 8'h01, 8'h7F, 1'b1};
        vecs[4] = '{"00_minus_80", 8'h00, 8'h80, 8'h80, 1'b1};
        vecs[5] = '{"80_minus_80", 8'h80, 8'h80, 8'h00, 1'b0};
        vecs[6] = '{"ff_minus_7f", 8'hFF, 8'h7F, 8'h80, 1'b0};
        vecs[7] = '{"7f_minus_80", 8'h7F, 8'h80, 8'hFF, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N_ELEM; i++) begin
                ma[i] = vecs[v].a;
                mb[i] = vecs[v].b;
                er[i] = vecs[v].r;
            end
            eovf = vecs[v].ovf;
            run_op(v % 3 == 1, v % 3 == 2, 1'b0, -1);
        end

        // Overflow confined to first and last elements.
        for (int i = 0; i < N_ELEM; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
            er[i] = 8'h00;
        end
        ma[0] = 8'h7F;  mb[0] = 8'hFF;  er[0] = 8'h80;
        ma[24] = 8'h80; mb[24] = 8'h01; er[24] = 8'h7F;
        eovf = 1'b1;
        run_op(1'b0, 1'b0, 1'b0, -1);

        for (int r = 0; r < 5; r++) begin
            fill_random();
            run_op(1'b1, 1'b1, 1'b0, -1);
        end

        // start pulses during LOAD_B and OUT must be ignored.
        fill_random();
        run_op(1'b1, 1'b1, 1'b1, -1);

        // clear after 5 output handshakes, then a fresh operation.
        fill_random();
        run_op(1'b0, 1'b0, 1'b0, 5);
        fill_random();
        run_op(1'b1, 1'b0, 1'b0, -1);

        // start and clear together in IDLE: stays idle.
        @(negedge clk);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        check("start_clear_busy", busy, 0);
        check("start_clear_in_ready", in_ready, 0);
        @(negedge clk);
        check("start_clear_busy2", busy, 0);

        // Asynchronous reset after 12 B beats.
        fill_random();
        begin_op();
        load_mat(1'b0, N_ELEM, 1'b1, 1'b0);
        load_mat(1'b1, 12, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        fill_random();
        run_op(1'b1, 1'b1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
